grf_wb_arbiter: RTL
===================

Name: grf_wb_arbiter

Overview:
- Write-side front end of the general register file (GRF).
- Merges two sources into the single GRF write port (RegWr/RWAddr/RWData):
  - the W-stage pipeline writeback, which cannot stall;
  - the multi-cycle mult/div unit (MDU) result port, which uses a valid/ready handshake.
- MDU results are buffered in a small FIFO and drained in cycles when the pipeline is not writing.
- Stale buffered results are killed when a newer pipeline write targets the same register.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, >=2).
- AW, 2, FIFO pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- pipe_we  input  1  W-stage write request.
- pipe_addr  input  5  W-stage destination register.
- pipe_data  input  32  W-stage write data.
- mdu_valid  input  1  MDU result valid.
- mdu_addr  input  5  MDU destination register.
- mdu_data  input  32  MDU result data.
- mdu_ready  output  1  FIFO can accept an MDU result.
- rs  input  5  D-stage source register 1, for pending check.
- rt  input  5  D-stage source register 2, for pending check.
- rs_pending  output  1  rs has an unwritten MDU result.
- rt_pending  output  1  rt has an unwritten MDU result.
- RegWr  output  1  GRF write enable (registered).
- RWAddr  output  5  GRF write address (registered).
- RWData  output  32  GRF write data (registered).

Behaviour:
- Reset (async, Reset_n=0):
  - RegWr=0, RWAddr=0, RWData=0.
  - FIFO empty, all entries invalid, pointers 0, count 0.
  - mdu_ready=1 as soon as reset is released.
  - Reset mid-operation discards all queued results; no partial write is issued.
- Accept rules, evaluated at each rising edge:
  - Pipe write is effective when pipe_we=1 and pipe_addr!=0. A pipe write with pipe_addr=0 is treated as idle.
  - MDU handshake fires when mdu_valid & mdu_ready.
  - A fired MDU result with mdu_addr=0 is consumed and not enqueued.
- mdu_ready = (count != DEPTH):
  - computed from registered count only;
  - no enqueue when full, even if a pop occurs in the same cycle.
- Output register priority:
  - Effective pipe write: RegWr<=1, RWAddr<=pipe_addr, RWData<=pipe_data. Latency is 1 cycle: accepted on edge k, visible after edge k.
  - Else, FIFO non-empty: pop head.
    - Head live: RegWr<=1 with head addr/data.
    - Head killed: RegWr<=0 (slot consumed silently).
  - Else: RegWr<=0; RWAddr/RWData hold their last value.
- MDU latency:
  - enqueued on edge k; earliest RegWr after edge k+1;
  - delayed by one cycle for each cycle pipe_we is active.
- Kill (WAW ordering):
  - An effective pipe write to register r clears the live bit of every FIFO entry with addr r.
  - Same-edge MDU handshake with mdu_addr==pipe_addr: the MDU result is consumed and not enqueued; the pipe write is treated as newer.
- Same-edge enqueue and pop: both take effect; count unchanged.
- Pointers wrap modulo DEPTH.
- FIFO order is strict; a killed entry still occupies its slot until popped.
- Pending detection (see Optional Feature):
  - x_pending=1 if any live FIFO entry has addr==x, or if RegWr=1 and RWAddr==x (write not yet committed in GRF).
  - x=0 always gives 0.
  - Combinational from registered state and rs/rt.

Optional Feature:
- Macro: GRF_WB_PENDING_EN.
- Defined:
  - rs_pending/rt_pending behave as described above;
  - hazard logic stalls D on these outputs.
- Undefined:
  - rs_pending=rt_pending=0 constantly;
  - address-compare logic is not built;
  - FIFO, kill and priority behaviour are unchanged.

Test Plan:
1. Reset_n=0 mid-operation with 3 entries queued, then release -> RegWr=0, RWAddr=0, RWData=0, mdu_ready=1, no write of queued data ever appears.
2. pipe_we=1, pipe_addr=5, pipe_data=32'h1234_5678 on edge k -> after edge k: RegWr=1, RWAddr=5, RWData=32'h1234_5678; next cycle with pipe idle -> RegWr=0.
3. MDU writes r8=32'hAAAA_0001 while pipe_we held 1 to r3 for 3 cycles:
   - -> r3 writes on 3 consecutive cycles;
   - -> r8 written on the first idle cycle;
   - -> rs=8 gives rs_pending=1 until the cycle after the r8 write.
4. Enqueue 4 MDU results while pipe_we=1 continuously:
   - -> mdu_ready=0 after the 4th;
   - -> 5th mdu_valid held, accepted only on the edge after the first pop;
   - -> all 5 written in order.
5. Enqueue MDU r9=32'h0000_0009, then pipe write r9=32'hFFFF_FFFF before the drain:
   - -> only the 32'hFFFF_FFFF write to r9 appears;
   - -> the killed slot drains with RegWr=0;
   - -> rt=9 gives rt_pending=0 after the kill, apart from the output stage.
6. pipe_we=1, pipe_addr=0, plus an MDU result with mdu_addr=0 -> RegWr stays 0, FIFO count stays 0, mdu_ready stays 1.

Source files
------------

// File: rtl/grf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter_if
// Bus bundle between the register-file write front end and its neighbours.
//   pipe_we/pipe_addr/pipe_data : W-stage writeback request (cannot stall)
//   mdu_valid/mdu_addr/mdu_data : MDU result offer, mdu_ready accepts it
//   rs/rt                       : D-stage source registers to check
//   rs_pending/rt_pending       : source still has an uncommitted MDU result
//   RegWr/RWAddr/RWData         : registered GRF write port
// Modports: master = environment side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface grf_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_pending;
    logic        rt_pending;
    logic        RegWr;
    logic [4:0]  RWAddr;
    logic [31:0] RWData;

    modport master (
        output pipe_we, pipe_addr, pipe_data,
        output mdu_valid, mdu_addr, mdu_data,
        output rs, rt,
        input  mdu_ready, rs_pending, rt_pending,
        input  RegWr, RWAddr, RWData
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  rs, rt,
        output mdu_ready, rs_pending, rt_pending,
        output RegWr, RWAddr, RWData
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter
// Write-side front end of the general register file. The W-stage writeback
// always wins the GRF write port; MDU results are queued in a DEPTH-entry
// FIFO and drained in cycles where the pipeline does not write. A pipeline
// write to register r kills every queued MDU result for r so that the newer
// pipeline value is never overwritten by an older MDU result.
// Ports:
//   clk     : clock, all state on rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : grf_wb_arbiter_if.slave (pipe, MDU, pending and GRF signals)
// Optional feature macro: GRF_WB_PENDING_EN builds the rs/rt pending
// compare; without it rs_pending/rt_pending are tied low.
// ---------------------------------------------------------------------------
module grf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    grf_wb_arbiter_if.slave        bus
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ZERO_CNT = {(AW + 1){1'b0}};

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [4:0]       fifo_addr_d [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [31:0]      fifo_data_d [DEPTH];
    logic [DEPTH-1:0] fifo_live_q, fifo_live_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       rw_addr_q, rw_addr_d;
    logic [31:0]      rw_data_q, rw_data_d;

    logic pipe_eff_s, mdu_ready_s, mdu_fire_s, enq_s, pop_s;

    // Accept decisions for this edge; ready depends on registered count only.
    always_comb begin
        pipe_eff_s  = bus.pipe_we && (bus.pipe_addr != 5'd0);
        mdu_ready_s = (count_q != FULL_CNT);
        mdu_fire_s  = bus.mdu_valid && mdu_ready_s;
        // r0 results and results overtaken by a same-edge pipe write are dropped.
        enq_s       = mdu_fire_s && (bus.mdu_addr != 5'd0) &&
                      !(pipe_eff_s && (bus.mdu_addr == bus.pipe_addr));
        pop_s       = !pipe_eff_s && (count_q != ZERO_CNT);
    end

    // FIFO next state: kill, pop, enqueue and occupancy.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_live_d = fifo_live_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_eff_s && (fifo_addr_q[i] == bus.pipe_addr)) begin
                fifo_live_d[i] = 1'b0;
            end else begin
                fifo_live_d[i] = fifo_live_q[i];
            end
        end
        if (pop_s) begin
            fifo_live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Enqueue never targets the head slot being popped: it needs a non-full
        // FIFO, and a pop needs a non-empty one, so the two slots differ.
        if (enq_s) begin
            fifo_addr_d[wr_ptr_q] = bus.mdu_addr;
            fifo_data_d[wr_ptr_q] = bus.mdu_data;
            fifo_live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // GRF write port: pipe first, then FIFO head; killed heads drain silently.
    always_comb begin
        reg_wr_d  = 1'b0;
        rw_addr_d = rw_addr_q;
        rw_data_d = rw_data_q;
        if (pipe_eff_s) begin
            reg_wr_d  = 1'b1;
            rw_addr_d = bus.pipe_addr;
            rw_data_d = bus.pipe_data;
        end else if (pop_s) begin
            reg_wr_d = fifo_live_q[rd_ptr_q];
            if (fifo_live_q[rd_ptr_q]) begin
                rw_addr_d = fifo_addr_q[rd_ptr_q];
                rw_data_d = fifo_data_q[rd_ptr_q];
            end else begin
                rw_addr_d = rw_addr_q;
                rw_data_d = rw_data_q;
            end
        end else begin
            reg_wr_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
            fifo_live_q <= {DEPTH{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= ZERO_CNT;
            reg_wr_q    <= 1'b0;
            rw_addr_q   <= 5'd0;
            rw_data_q   <= 32'd0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            fifo_live_q <= fifo_live_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_wr_q    <= reg_wr_d;
            rw_addr_q   <= rw_addr_d;
            rw_data_q   <= rw_data_d;
        end
    end

    assign bus.mdu_ready = mdu_ready_s;
    assign bus.RegWr     = reg_wr_q;
    assign bus.RWAddr    = rw_addr_q;
    assign bus.RWData    = rw_data_q;

`ifdef GRF_WB_PENDING_EN
    logic rs_hit_s, rt_hit_s;

    // A source is pending while a live queued result or the uncommitted
    // output stage targets it; r0 is never pending.
    always_comb begin
        rs_hit_s = reg_wr_q && (rw_addr_q == bus.rs);
        rt_hit_s = reg_wr_q && (rw_addr_q == bus.rt);
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit_s = rs_hit_s | (fifo_live_q[i] && (fifo_addr_q[i] == bus.rs));
            rt_hit_s = rt_hit_s | (fifo_live_q[i] && (fifo_addr_q[i] == bus.rt));
        end
    end

    assign bus.rs_pending = rs_hit_s && (bus.rs != 5'd0);
    assign bus.rt_pending = rt_hit_s && (bus.rt != 5'd0);
`else
    logic unused_src_s;
    assign unused_src_s   = ^{bus.rs, bus.rt};
    assign bus.rs_pending = 1'b0;
    assign bus.rt_pending = 1'b0;
`endif

endmodule
